// File: rtl/mac_writeback_unit.sv
// Iterative shift-add multiply-accumulate feeding the register-file write port.
// Optional macro MAC_EARLY_EXIT_EN: leave MUL once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for start; writeData holds last result
// MUL   | one shift-add iteration per cycle
// WB    | single-cycle register-file write of acc + product
module mac_writeback_unit #(
  parameter int ACC_REG = 17,
  parameter int CNT_W   = 5
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  input  logic        clear,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] acc_in,
  output logic        busy,
  output logic        done,
  output logic        RegWrite,
  output logic [4:0]  Write_Reg,
  output logic [31:0] writeData
);

  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

  state_t           state, state_nxt;
  // Only the low half of the product is ever written back, so the upper half is not kept.
  logic [31:0]      a_sh, b_sh, acc, prod, prod_nxt, wdata_q;
  logic [CNT_W-1:0] cnt;
  logic             mul_last;

  always_comb begin
    prod_nxt = b_sh[0] ? (prod + a_sh) : prod;
  end

  always_comb begin
    mul_last = (cnt == {CNT_W{1'b1}});
`ifdef MAC_EARLY_EXIT_EN
    if (b_sh[31:1] == 31'd0) mul_last = 1'b1;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL;
      MUL:     if (mul_last) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == WB);
    RegWrite  = (state == WB);
    Write_Reg = (state == WB) ? 5'(ACC_REG) : 5'd0;
    writeData = wdata_q;
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      prod    <= '0;
      cnt     <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= op_a;
            b_sh <= op_b;
            acc  <= clear ? 32'd0 : acc_in;
            prod <= '0;
            cnt  <= '0;
          end
        end
        MUL: begin
          prod <= prod_nxt;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
          // Result is registered on the way into WB so the outputs stay state-only.
          if (mul_last) wdata_q <= acc + prod_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_writeback_unit.sv
// Directed scoreboard bench for mac_writeback_unit; honours MAC_EARLY_EXIT_EN for expected latency.
module tb_mac_writeback_unit;

  logic        clock = 1'b0;
  logic        rst;
  logic        start;
  logic        clear;
  logic [31:0] op_a, op_b, acc_in;
  logic        busy, done, RegWrite;
  logic [4:0]  Write_Reg;
  logic [31:0] writeData;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  mac_writeback_unit #(.ACC_REG(17), .CNT_W(5)) dut (
    .clock(clock), .rst(rst), .start(start), .clear(clear),
    .op_a(op_a), .op_b(op_b), .acc_in(acc_in),
    .busy(busy), .done(done), .RegWrite(RegWrite),
    .Write_Reg(Write_Reg), .writeData(writeData)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] b);
`ifdef MAC_EARLY_EXIT_EN
    int m = 0;
    for (int i = 0; i < 32; i++) if (b[i]) m = i + 1;
    return ((m < 1) ? 1 : m) + 1;
`else
    return 33;
`endif
  endfunction

  // Called at a negedge: issues start for edge E0, re-pulses start at E5/E20 when asked,
  // scrambles the inputs after E0 and checks the single write against the scoreboard.
  task automatic run_mac(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] acc, input logic clr, input bit repulse);
    exp_t e, got;
    int   k;
    bit   found;
    e.data = (clr ? 32'd0 : acc) + a * b;
    e.lat  = exp_lat(b);
    op_a = a; op_b = b; acc_in = acc; clear = clr; start = 1'b1;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
    start  = 1'b0;
    op_a   = $urandom; op_b = $urandom; acc_in = $urandom; clear = 1'b0;
    check({tag, " busy after start"}, 32'(busy), 32'd1);
    k = 0;
    found = 1'b0;
    while (!found && k < 45) begin
      if (RegWrite) begin
        found = 1'b1;
        got = sb.pop_front();
        check({tag, " writeData"}, writeData, got.data);
        check({tag, " Write_Reg"}, 32'(Write_Reg), 32'd17);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " latency"}, k + 1, got.lat);
      end else begin
        start = (repulse && (k == 4 || k == 19)) ? 1'b1 : 1'b0;
        if (start) clear = 1'b1;
        @(negedge clock);
        k++;
        start = 1'b0;
      end
    end
    check({tag, " write seen"}, 32'(found), 32'd1);
    @(negedge clock);
    check({tag, " RegWrite dropped"}, 32'(RegWrite), 32'd0);
    check({tag, " busy dropped"}, 32'(busy), 32'd0);
    check({tag, " writeData held"}, writeData, e.data);
  endtask

  task automatic quiet(input string tag, input int n);
    int writes = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (RegWrite) writes++;
    end
    check({tag, " no RegWrite"}, writes, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; clear = 1'b0;
    op_a = '0; op_b = '0; acc_in = '0;
    repeat (3) @(negedge clock);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset RegWrite", 32'(RegWrite), 32'd0);
    check("reset Write_Reg", 32'(Write_Reg), 32'd0);
    check("reset writeData", writeData, 32'd0);
    rst = 1'b1;
    @(negedge clock);

    run_mac("basic", 32'd3, 32'd5, 32'd10, 1'b0, 1'b0);
    run_mac("clear", 32'd7, 32'd6, 32'h1234, 1'b1, 1'b0);
    run_mac("wrap_mul", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 1'b1, 1'b0);
    run_mac("wrap_acc", 32'd1, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_mac("restart", 32'd9, 32'h8000_0001, 32'd2, 1'b0, 1'b1);
    quiet("restart after", 40);
    check("restart queue empty", sb.size(), 0);

    // Reset asserted at E10 of an active MAC.
    op_a = 32'd11; op_b = 32'hFFFF_FFFF; acc_in = 32'd3; clear = 1'b0; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset RegWrite", 32'(RegWrite), 32'd0);
    check("midreset Write_Reg", 32'(Write_Reg), 32'd0);
    check("midreset writeData", writeData, 32'd0);
    rst = 1'b1;
    quiet("midreset after", 40);

    run_mac("early_b0", 32'h1357_9BDF, 32'd0, 32'h0000_ABCD, 1'b0, 1'b0);
    run_mac("early_b5", 32'd4, 32'd5, 32'd1, 1'b0, 1'b0);
    run_mac("random", 32'hDEAD_BEEF, 32'h0001_0203, 32'hCAFE_F00D, 1'b0, 1'b0);
    check("final queue empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_writeback_unit.md
# mac_writeback_unit

Iterative multiply-accumulate unit for the multicycle processor. It sits directly upstream of the register file's write port and downstream of its read ports. It takes two operands from `Read_Data1`/`Read_Data2` and the current accumulator value from `ReadMAC` (register 17). It forms `acc + a*b` with a radix-2 shift-add multiplier and issues a single register-file write of the result back to the accumulator register.

## Interface
Parameters:
- `ACC_REG`, default 17: register-file index written with the result; must match the register driving `ReadMAC`.
- `CNT_W`, default 5: iteration counter width; 32 iterations maximum.

Ports:
- `clock`  in  1: sole clock; all state updates on its rising edge.
- `rst`  in  1: reset. One clock; reset is synchronous and active-low.
- `start`  in  1: request a MAC; sampled only in IDLE.
- `clear`  in  1: sampled with `start`; 1 means the accumulator operand is taken as 0, i.e. a plain multiply.
- `op_a`  in  32: multiplicand, from `Read_Data1`.
- `op_b`  in  32: multiplier, from `Read_Data2`.
- `acc_in`  in  32: accumulator, from `ReadMAC`.
- `busy`  out  1: high in MUL and WB.
- `done`  out  1: one-cycle pulse, coincident with `RegWrite`.
- `RegWrite`  out  1: write strobe to the register file.
- `Write_Reg`  out  5: write address; equals `ACC_REG` when `RegWrite` is 1, otherwise 0.
- `writeData`  out  32: write data; holds the last result after WB.

## Operation
- States are IDLE, MUL and WB. Encoding is free.
- **IDLE, `start`=1:**
  - Latch `a_sh`={32'b0, op_a} (64 bits) and `b_sh`=op_b.
  - Latch `acc` = `clear` ? 0 : `acc_in`.
  - Clear `prod` (64 bits) and `cnt`, then go to MUL.
- **IDLE, `start`=0:** no state change.
- **MUL, each cycle:**
  - If `b_sh[0]`, then `prod` <= `prod` + `a_sh`.
  - `a_sh` <= `a_sh`<<1; `b_sh` <= `b_sh`>>1; `cnt` <= `cnt`+1.
  - Exit to WB when `cnt`==31, i.e. after 32 iterations.
- **WB, one cycle:**
  - `RegWrite`=1, `Write_Reg`=`ACC_REG`, `writeData`=(`acc` + `prod[31:0]`) mod 2^32, `done`=1.
  - Next state is IDLE.
- **Arithmetic:**
  - Only the low 32 bits of the product are used, so signed and unsigned operands give identical results.
  - The accumulate wraps modulo 2^32; there is no overflow flag.
- **Boundary conditions:**
  - `start` in MUL or WB is ignored and not queued.
  - `clear` is ignored without `start`.
  - Operands and `acc_in` may change freely after the start edge; only the latched copies are used.
- **Reset** (`rst`=0 at an edge), including mid-MUL or in WB:
  - Go to IDLE; no write is issued.
  - `busy`, `done`, `RegWrite` = 0; `Write_Reg` = 0; `writeData` = 0; `prod`/`cnt` cleared.

## Timing
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Start edge E0 enters MUL and `busy` rises after E0.
- Without the early-exit feature, MUL occupies 32 cycles (E1..E32).
- WB is active during the cycle after E32, and the register file captures the write at E33. Latency from start edge to write edge is 33 cycles.
- `busy` falls after E33.
- Back-to-back: a new `start` is accepted at E34 at the earliest.
- `acc_in` is read only at E0. The write lands at E33, so a following MAC sees the updated r17 provided the controller asserts `start` no earlier than E34.

## Configuration
- `MAC_EARLY_EXIT_EN` defined:
  - MUL also exits to WB when the post-shift multiplier is zero (`b_sh[31:1]`==0).
  - MUL therefore lasts max(1, msb_index(op_b)+1) cycles; for `op_b`=0 that is 1 cycle, giving write-edge latency 2.
  - The result is unchanged.
- `MAC_EARLY_EXIT_EN` undefined: MUL always lasts exactly 32 cycles and latency is fixed at 33.

## Test plan
- After reset release, `op_a`=3, `op_b`=5, `acc_in`=10, `start` for one cycle: a single `RegWrite`/`done` pulse with `Write_Reg`=17 and `writeData`=25, captured 33 edges after start (macro off).
- `clear`=1 with `start`, `op_a`=7, `op_b`=6, `acc_in`=0x1234: `writeData`=42.
- Wrap cases:
  - `op_a`=`op_b`=0xFFFFFFFF, `clear`=1: `writeData`=0x00000001.
  - `op_a`=1, `op_b`=1, `acc_in`=0xFFFFFFFF: `writeData`=0.
- `start` re-pulsed at E5 and E20 of an active MAC: exactly one write, with the result of the first operands.
- `rst`=0 at E10 of MUL: all outputs 0 from the next cycle; no `RegWrite` over the following 40 cycles.
- Macro on:
  - `op_b`=0: `RegWrite` at the second edge after start with `writeData`=`acc_in`.
  - `op_b`=5, `op_a`=4, `acc_in`=1: `writeData`=21 with 3 MUL cycles, write edge at E4.
